// File: rtl/systolic_ws_ctrl.sv
// systolic_ws_ctrl: sequencer for an NxN weight-stationary MAC array.
//   Loads one weight tile (last row first) down the vertical weight path,
//   streams len activation vectors through a per-row input skew, and deskews
//   the bottom-row column sums into aligned output vectors with address/valid.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, len, reuse_wt      job request (sampled in IDLE), batch length, weight reuse
//   busy, done                job in progress, one-cycle end-of-job pulse
//   w_rd_en/addr/data         weight buffer read (1-cycle latency), row index
//   a_rd_en/addr/data         activation buffer read (1-cycle latency), vector index
//   arr_wt_load, arr_wt_in    array weight latch enable and top-row weight inputs
//   arr_data_in, arr_acc_out  left-column activations, bottom-row accumulations
//   out_valid/addr/data       aligned result vector
// Configuration: SYSTOLIC_CTRL_WT_REUSE_EN lets reuse_wt=1 skip the weight load.
module systolic_ws_ctrl #(
   parameter int N         = 4,
   parameter int bit_width = 8,
   parameter int acc_width = 32,
   parameter int LEN_W     = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [LEN_W-1:0]         len,
   input  logic                     reuse_wt,
   output logic                     busy,
   output logic                     done,
   output logic                     w_rd_en,
   output logic [LEN_W-1:0]         w_rd_addr,
   input  logic [N*bit_width-1:0]   w_rd_data,
   output logic                     a_rd_en,
   output logic [LEN_W-1:0]         a_rd_addr,
   input  logic [N*bit_width-1:0]   a_rd_data,
   output logic                     arr_wt_load,
   output logic [N*bit_width-1:0]   arr_wt_in,
   output logic [N*bit_width-1:0]   arr_data_in,
   input  logic [N*acc_width-1:0]   arr_acc_out,
   output logic                     out_valid,
   output logic [LEN_W-1:0]         out_addr,
   output logic [N*acc_width-1:0]   out_data
);
   typedef enum logic [2:0] {IDLE, WLOAD, STREAM, DRAIN, DONE} state_t;
   localparam logic [LEN_W-1:0] LAST_W = LEN_W'(N-1);
   localparam logic [LEN_W-1:0] LAST_D = LEN_W'(2*N-1);

   state_t           state_q, state_d;
   logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d;
   logic             skip_wl;

`ifdef SYSTOLIC_CTRL_WT_REUSE_EN
   assign skip_wl = reuse_wt;
`else
   logic unused_reuse;
   assign skip_wl = 1'b0;
   assign unused_reuse = reuse_wt;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
      end
   end

   // With len=0 STREAM still lasts one (read-free) cycle so that done follows
   // the last weight latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      busy      = state_q != IDLE;
      done      = 1'b0;
      w_rd_en   = 1'b0;
      w_rd_addr = '0;
      a_rd_en   = 1'b0;
      a_rd_addr = '0;
      case (state_q)
         IDLE: if (start) begin
            len_d   = len;
            cnt_d   = '0;
            state_d = skip_wl ? STREAM : WLOAD;
         end
         WLOAD: begin
            w_rd_en   = 1'b1;
            w_rd_addr = LAST_W - cnt_q;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == LAST_W) begin
               cnt_d   = '0;
               state_d = STREAM;
            end
         end
         STREAM: begin
            a_rd_en   = len_q != '0;
            a_rd_addr = cnt_q;
            cnt_d     = cnt_q + 1'b1;
            if (len_q == '0 || cnt_q == len_q - 1'b1) begin
               cnt_d   = '0;
               state_d = len_q == '0 ? DONE : DRAIN;
            end
         end
         DRAIN: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_D) begin
               cnt_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   logic                   wt_load_q, a_vld_q;
   logic [2*N-1:0]         vld_q;
   logic [2*N*LEN_W-1:0]   adr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wt_load_q <= 1'b0;
         a_vld_q   <= 1'b0;
         vld_q     <= '0;
         adr_q     <= '0;
      end else begin
         wt_load_q <= w_rd_en;
         a_vld_q   <= a_rd_en;
         vld_q     <= {vld_q[2*N-2:0], a_rd_en};
         adr_q     <= {adr_q[(2*N-1)*LEN_W-1:0], a_rd_addr};
      end
   end

   assign arr_wt_load = wt_load_q;
   assign arr_wt_in   = wt_load_q ? w_rd_data : '0;
   assign out_valid   = vld_q[2*N-1];
   assign out_addr    = adr_q[2*N*LEN_W-1 -: LEN_W];

   // Input skew: row r is delayed by r cycles; empty slots are forced to 0.
   for (genvar r = 0; r < N; r++) begin : g_skew
      logic [bit_width-1:0] a_r;
      assign a_r = a_vld_q ? a_rd_data[r*bit_width +: bit_width] : '0;
      if (r == 0) begin : g_direct
         assign arr_data_in[bit_width-1:0] = a_r;
      end else begin : g_pipe
         logic [r-1:0][bit_width-1:0] sk_q;
         always_ff @(posedge clk) begin
            if (rst) sk_q <= '0;
            else begin
               sk_q[0] <= a_r;
               for (int k = 1; k < r; k++) sk_q[k] <= sk_q[k-1];
            end
         end
         assign arr_data_in[r*bit_width +: bit_width] = sk_q[r-1];
      end
   end

   // Output deskew: column j leaves the array j cycles late, so it is
   // delayed by N-1-j cycles to line up with column N-1.
   for (genvar j = 0; j < N; j++) begin : g_deskew
      localparam int D = N - 1 - j;
      logic [acc_width-1:0] c_j;
      if (D == 0) begin : g_direct
         assign c_j = arr_acc_out[j*acc_width +: acc_width];
      end else begin : g_pipe
         logic [D-1:0][acc_width-1:0] ds_q;
         always_ff @(posedge clk) begin
            if (rst) ds_q <= '0;
            else begin
               ds_q[0] <= arr_acc_out[j*acc_width +: acc_width];
               for (int k = 1; k < D; k++) ds_q[k] <= ds_q[k-1];
            end
         end
         assign c_j = ds_q[D-1];
      end
      assign out_data[j*acc_width +: acc_width] = out_valid ? c_j : '0;
   end
endmodule

// File: doc/systolic_ws_ctrl.md
# systolic_ws_ctrl

Sequencer for the 4×4 weight-stationary MAC array.

- Loads one weight tile into the array through the vertical weight path.
- Streams a batch of activation vectors in with a per-row skew.
- Deskews the column accumulations leaving the bottom row into aligned output vectors with an address and a valid.
- Sits between the weight/activation buffers (1-cycle read latency) and the output buffer, under a start/done handshake from the layer scheduler.

## Interface
Parameters:
- N, 4, array dimension (rows = columns)
- bit_width, 8, activation/weight width
- acc_width, 32, accumulator width
- LEN_W, 8, width of batch length and vector addresses

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  begin a job; sampled only in IDLE
- len  in  LEN_W  number of activation vectors; captured at start
- reuse_wt  in  1  skip weight load (honoured only with the configuration macro)
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at job end
- w_rd_en / w_rd_addr  out  1 / LEN_W  weight-buffer read; row index
- w_rd_data  in  N*bit_width  weight row; valid 1 cycle after w_rd_en
- a_rd_en / a_rd_addr  out  1 / LEN_W  activation-buffer read; vector index
- a_rd_data  in  N*bit_width  activation vector; element r in bits [r*bit_width +: bit_width]
- arr_wt_load  out  1  array control (weight latch enable)
- arr_wt_in  out  N*bit_width  top-row weight path inputs
- arr_data_in  out  N*bit_width  left-column activation inputs, row r in slice r
- arr_acc_out  in  N*acc_width  bottom-row acc outputs, column j in slice j
- out_valid / out_addr / out_data  out  1 / LEN_W / N*acc_width  aligned result vector

## Operation
- States: IDLE → WLOAD → STREAM → DRAIN → DONE → IDLE.
- IDLE → WLOAD on start. With the macro and reuse_wt=1, IDLE → STREAM directly.
- WLOAD (N cycles):
  - On cycle k = 0..N-1, assert w_rd_en with w_rd_addr = N-1-k (last row first).
  - arr_wt_load = w_rd_en delayed 1 cycle; arr_wt_in = w_rd_data on those cycles, else 0.
  - After the N-th load cycle, array row r holds weight row r.
- STREAM (len cycles): a_rd_en high with a_rd_addr = 0..len-1.
- DRAIN: exactly 2N cycles, flushing skew, array and deskew.
- DONE: one cycle; done=1.
- len=0: WLOAD (if any) → DONE, with no activation reads and no out_valid.
- Skew: element r of a read vector passes through r registers before reaching arr_data_in[r]. Slots without valid data carry 0.
- Deskew: column j of arr_acc_out passes through N-1-j registers.
- out_data[j] = Σ_r a[r]·W[r][j], truncated to acc_width (wraps modulo 2^acc_width).
- out_addr = index of the source vector; results are emitted in read order, one per cycle.
- start while busy is ignored.
- rst in any state:
  - next state IDLE; all outputs 0.
  - Skew/deskew pipes and the valid/address pipe are cleared.
  - Array weights are not cleared; a later reuse job is undefined until a fresh load.
- The array's top acc_in is tied to 0 outside this block.

## Timing
- Reset values of all outputs: 0.
- start accepted at cycle s: busy=1 from s+1; first w_rd_en at s+1.
- arr_wt_load high on s+2..s+N+1.
- First a_rd_en at s+N+1, so data reaches the array after the last weight latch.
- a_rd_en at cycle c → arr_data_in[r] at c+1+r → arr_acc_out[j] at c+1+N+j → out_valid with out_addr at c+2N.
- Pipeline latency: 2N cycles (8 for N=4).
- Last out_valid falls in the final DRAIN cycle; done on the next cycle; busy falls with done.
- Throughput: one vector per cycle; no back-pressure, and the output buffer must accept every out_valid.
- Back-to-back jobs: start is accepted in the cycle after done.

## Configuration
- SYSTOLIC_CTRL_WT_REUSE_EN defined: reuse_wt=1 at start skips WLOAD and keeps resident weights. First a_rd_en at s+1.
- Not defined: reuse_wt is ignored and every job performs WLOAD.

## Test plan
- Weight load: W[r][j] = 10r+j, start, len=1, a=[1,0,0,0] → out_data = [0,1,2,3] at out_addr 0, exactly 8 cycles after the a_rd_en.
- Identity weights, len=4, vectors [1,2,3,4], [5,6,7,8], [9,10,11,12], [13,14,15,16] → the same vectors on 4 consecutive out_valid cycles with addresses 0..3. Then done, busy falls.
- Wrap: W all 255, a all 255, acc_width=16 → out_data[j] = (4·65025) mod 65536 = 63492.
- len=0 → 4 weight reads, no a_rd_en, no out_valid, done at s+N+2.
- rst asserted mid-STREAM → next cycle busy=0, out_valid=0. A new start then runs a full job correctly.
- Macro defined, reuse_wt=1 after a prior load → no w_rd_en, results correct with the prior weights. Macro undefined → reuse_wt ignored and weights reloaded.
